// File: rtl/result_display_pkg.sv
// Shared types and 7-segment constants for the result display path.
// Segment encodings are {g,f,e,d,c,b,a}, active low.
package result_display_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} bcd_state_t;

  localparam int NUM_RESULTS = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Entry n is the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_DIGITS[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, free-running LOAD -> SHIFT -> DONE.
// i_tag is captured alongside the magnitude so flags stay paired with their value.
module bin2bcd_seq
  import result_display_pkg::*;
#(
  parameter int MAG_BITS = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_skip,
  input  logic [MAG_BITS-1:0] i_mag,
  input  logic [1:0]          i_tag,
  output logic                o_done,
  output logic [15:0]         o_bcd,
  output logic [1:0]          o_tag
);

  localparam int CW = $clog2(MAG_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(MAG_BITS - 1);

  bcd_state_t          r_state;
  logic [MAG_BITS-1:0] r_mag;
  logic [15:0]         r_bcd;
  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_tag;
  logic [15:0]         w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mag   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_tag   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_mag   <= i_mag;
          r_tag   <= i_tag;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= i_skip ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          {r_bcd, r_mag} <= {w_adj[14:0], r_mag, 1'b0};
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= ST_DONE;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign o_done = (r_state == ST_DONE);
  assign o_bcd  = r_bcd;
  assign o_tag  = r_tag;

endmodule

// File: rtl/result_display_scanner.sv
// Result selector + decimal conversion + 4-digit multiplexed 7-segment driver.
// The display register is only written on converter DONE, so the image never tears.
module result_display_scanner
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int MAG_BITS    = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result_suma,
  input  logic [31:0] result_resta,
  input  logic [31:0] result_mult,
  input  logic [31:0] result_div,
  input  logic [31:0] result_pow,
  input  logic        btn_next,
  output logic [4:0]  sel_led,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [2:0]    SEL_LAST = 3'(NUM_RESULTS - 1);

  logic [2:0]          r_sel;
  logic                r_btn_q;
  logic                w_btn_rise;
  logic signed [31:0]  w_v;
  logic                w_pos, w_neg, w_ovf;
  logic [MAG_BITS-1:0] w_mag;
  logic                w_done;
  logic [15:0]         w_bcd;
  logic [1:0]          w_tag;
  logic [15:0]         r_disp_bcd;
  logic                r_disp_neg, r_disp_ovf, r_disp_vld;
  logic [RW-1:0]       r_refresh;
  logic [1:0]          r_digit;
  logic                r_scan_en;
  logic [3:0]          w_nib;
  logic                w_lead_zero;
  logic [6:0]          w_seg;
  logic [3:0]          r_an;
  logic [6:0]          r_seg;

  assign w_btn_rise = btn_next & ~r_btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel   <= '0;
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= btn_next;
      if (w_btn_rise) r_sel <= (r_sel == SEL_LAST) ? 3'd0 : r_sel + 3'd1;
    end
  end

  assign sel_led = 5'd1 << r_sel;

  always_comb begin
    case (r_sel)
      3'd0:    w_v = result_suma;
      3'd1:    w_v = result_resta;
      3'd2:    w_v = result_mult;
      3'd3:    w_v = result_div;
      3'd4:    w_v = result_pow;
      default: w_v = '0;
    endcase
  end

  assign w_pos = (w_v >= 32'sd0) && (w_v <= 32'sd9999);
  assign w_neg = (w_v < 32'sd0) && (w_v >= -32'sd999);
  assign w_ovf = ~(w_pos | w_neg);
  assign w_mag = MAG_BITS'(w_pos ? w_v : (w_neg ? -w_v : 32'sd0));

  bin2bcd_seq #(.MAG_BITS(MAG_BITS)) u_bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (1'b1),
    .i_skip  (w_ovf),
    .i_mag   (w_mag),
    .i_tag   ({w_ovf, w_neg}),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_tag   (w_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_bcd <= '0;
      r_disp_neg <= 1'b0;
      r_disp_ovf <= 1'b0;
      r_disp_vld <= 1'b0;
    end else if (w_done) begin
      r_disp_bcd <= w_bcd;
      r_disp_ovf <= w_tag[1];
      r_disp_neg <= w_tag[0];
      r_disp_vld <= 1'b1;
    end
  end

  // First wrap only enables scanning, so digit0 is the first digit lit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_digit   <= '0;
      r_scan_en <= 1'b0;
    end else if (r_refresh == REF_LAST) begin
      r_refresh <= '0;
      if (r_scan_en) r_digit <= r_digit + 2'd1;
      else           r_scan_en <= 1'b1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  assign w_nib = r_disp_bcd[{r_digit, 2'b00} +: 4];

  always_comb begin
    case (r_digit)
      2'd3:    w_lead_zero = (r_disp_bcd[15:12] == '0);
      2'd2:    w_lead_zero = (r_disp_bcd[15:8]  == '0);
      2'd1:    w_lead_zero = (r_disp_bcd[15:4]  == '0);
      default: w_lead_zero = 1'b0;
    endcase
  end

  always_comb begin
    w_seg = SEG_BLANK;
    if (!r_disp_vld)                      w_seg = SEG_BLANK;
    else if (r_disp_ovf)                  w_seg = SEG_E;
    else if (r_disp_neg && r_digit == 3)  w_seg = SEG_MINUS;
    else if (w_lead_zero)                 w_seg = SEG_BLANK;
    else                                  w_seg = seg_of_digit(w_nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'hF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= r_scan_en ? ~(4'b0001 << r_digit) : 4'hF;
      r_seg <= r_scan_en ? w_seg : SEG_BLANK;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_result_display_scanner.sv
// Directed bench: expected digit images are queued when inputs change and
// compared against the scanned an/seg outputs.
module tb_result_display_scanner;

  typedef logic [3:0][6:0] image_t;

  localparam logic [6:0] T_BLANK = 7'h7F;
  localparam logic [6:0] T_MINUS = 7'b0111111;
  localparam logic [6:0] T_E     = 7'b0000110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_next = 1'b0;
  logic [31:0] suma, resta, mult, divr, pw;
  logic [4:0]  sel_led;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  image_t q_exp[$];

  always #5 clk = ~clk;

  result_display_scanner #(.REFRESH_DIV(4), .MAG_BITS(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .result_suma  (suma),
    .result_resta (resta),
    .result_mult  (mult),
    .result_div   (divr),
    .result_pow   (pw),
    .btn_next     (btn_next),
    .sel_led      (sel_led),
    .an           (an),
    .seg          (seg)
  );

  function automatic logic [6:0] dseg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic image_t model(input logic signed [31:0] v);
    image_t img;
    int m;
    logic neg;
    if (v > 9999 || v < -999) return {T_E, T_E, T_E, T_E};
    neg = (v < 0);
    m = neg ? -v : v;
    img[0] = dseg(m % 10);
    img[1] = (m >= 10)  ? dseg((m / 10) % 10)  : T_BLANK;
    img[2] = (m >= 100) ? dseg((m / 100) % 10) : T_BLANK;
    img[3] = neg ? T_MINUS : ((m >= 1000) ? dseg((m / 1000) % 10) : T_BLANK);
    return img;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    btn_next = 1'b1;
    tick(2);
    btn_next = 1'b0;
    tick(2);
  endtask

  // Pops one expected image and walks the scan digit0..digit3.
  task automatic scan(input string tag);
    image_t e;
    logic ok;
    logic [3:0] want;
    e = q_exp.pop_front();
    for (int d = 0; d < 4; d++) begin
      want = ~(4'b0001 << d);
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
        @(negedge clk);
        if (an === want) ok = 1'b1;
      end
      chk($sformatf("%s an_d%0d_seen", tag, d), {31'd0, ok}, 32'd1);
      chk($sformatf("%s seg_d%0d", tag, d), {25'd0, seg}, {25'd0, e[d]});
    end
  endtask

  task automatic show(input string tag, input logic [31:0] v);
    q_exp.push_back(model(v));
    tick(40);
    scan(tag);
  endtask

  logic [31:0] words [5];
  logic [4:0]  led_seq [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
  logic [31:0] bounds [7] = '{32'd0, 32'd9999, -32'sd999, -32'sd1000, 32'd10000,
                              32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    suma = 32'd1234; resta = -32'sd56; mult = 32'd10000; divr = -32'sd1000; pw = 32'd7;
    words = '{suma, resta, mult, divr, pw};

    tick(3);
    chk("rst sel_led", {27'd0, sel_led}, 32'h01);
    chk("rst an", {28'd0, an}, 32'hF);
    chk("rst seg", {25'd0, seg}, 32'h7F);
    reset = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk($sformatf("an_off c%0d", k), {28'd0, an}, 32'hF);
    end
    tick(1);
    chk("an first digit0", {28'd0, an}, 32'hE);
    tick(11);
    chk("c16 an", {28'd0, an}, 32'hB);
    chk("c16 seg blank", {25'd0, seg}, 32'h7F);
    tick(2);
    chk("c18 an", {28'd0, an}, 32'h7);
    chk("c18 seg", {25'd0, seg}, {25'd0, dseg(1)});
    show("suma1234", suma);

    for (int i = 0; i < 5; i++) begin
      press();
      chk($sformatf("sel_led step%0d", i), {27'd0, sel_led}, {27'd0, led_seq[i]});
      show($sformatf("sel%0d", (i + 1) % 5), words[(i + 1) % 5]);
    end

    btn_next = 1'b1;
    tick(100);
    chk("hold once", {27'd0, sel_led}, 32'h02);
    btn_next = 1'b0;
    tick(3);
    chk("hold released", {27'd0, sel_led}, 32'h02);
    for (int i = 1; i < 5; i++) begin
      press();
      chk($sformatf("sel_led back%0d", i), {27'd0, sel_led}, {27'd0, led_seq[i]});
    end

    foreach (bounds[i]) begin
      suma = bounds[i];
      show($sformatf("bound%0d", i), suma);
    end

    // Input change in the middle of a conversion: old value must still be shown.
    suma = 32'd1234;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(22);
    suma = 32'd9;
    tick(13);
    chk("midshift an", {28'd0, an}, 32'h7);
    chk("midshift seg old", {25'd0, seg}, {25'd0, dseg(1)});
    show("suma9", suma);

    suma = 32'd5678;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
    btn_next = 1'b1;
    tick(2);
    btn_next = 1'b0;
    tick(2);
    chk("pre-reset sel_led", {27'd0, sel_led}, 32'h02);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("midrst an", {28'd0, an}, 32'hF);
    chk("midrst seg", {25'd0, seg}, 32'h7F);
    chk("midrst sel_led", {27'd0, sel_led}, 32'h01);
    reset = 1'b0;
    tick(16);
    chk("rec c16 seg blank", {25'd0, seg}, 32'h7F);
    tick(2);
    chk("rec c18 an", {28'd0, an}, 32'h7);
    chk("rec c18 seg", {25'd0, seg}, {25'd0, dseg(5)});
    show("recover5678", suma);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
